// File: rtl/mos_seq.sv
// MOS switch request sequencer: turns a one-shot command into a mos_req/mos_val
// handshake and reports done, timeout or dropped to the core controller.
module mos_seq #(
    parameter int ACK_BLANK = 3,
    parameter int GAP_CYC   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_start,
    input  logic        cmd_val,
    output logic        cmd_busy,
    output logic        cmd_done,
    output logic        cmd_err,
    output logic        cmd_drop,
    output logic [15:0] done_cnt,
    output logic        mos_req,
    output logic        mos_val,
    input  logic        mos_ack,
    input  logic [7:0]  reg_req_hold,
    input  logic [15:0] reg_ack_timeout
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2,
        GAP      = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] elapsed_reg, elapsed_next;
    logic [7:0]  hold_reg, hold_next;
    logic [7:0]  gap_reg, gap_next;
    logic        mos_req_reg, mos_req_next;
    logic        mos_val_reg, mos_val_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        err_reg, err_next;
    logic        drop_reg, drop_next;
    logic [15:0] done_cnt_reg, done_cnt_next;

    logic        ack_ok;
    logic        timeout_hit;
    logic [15:0] elapsed_inc;

    // The blanking window hides a level-high ack left over from the previous
    // transaction until the controller has had time to see the new request edge.
    assign ack_ok      = mos_ack && (elapsed_reg >= 16'(ACK_BLANK));
    assign timeout_hit = (reg_ack_timeout != 16'd0) && (elapsed_reg == reg_ack_timeout);
    assign elapsed_inc = (elapsed_reg == 16'hFFFF) ? elapsed_reg : elapsed_reg + 16'd1;

    always_comb begin
        state_next    = state_reg;
        elapsed_next  = elapsed_reg;
        hold_next     = hold_reg;
        gap_next      = gap_reg;
        mos_req_next  = mos_req_reg;
        mos_val_next  = mos_val_reg;
        done_cnt_next = done_cnt_reg;
        done_next     = 1'b0;
        err_next      = 1'b0;
        drop_next     = cmd_start && (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                if (cmd_start) begin
                    mos_val_next = cmd_val;
                    mos_req_next = 1'b1;
                    elapsed_next = 16'd0;
                    hold_next    = (reg_req_hold == 8'd0) ? 8'd1 : reg_req_hold;
                    state_next   = REQ;
                end
            end
            REQ, WAIT_ACK: begin
                elapsed_next = elapsed_inc;
                if (ack_ok) begin
                    mos_req_next  = 1'b0;
                    done_next     = 1'b1;
                    done_cnt_next = done_cnt_reg + 16'd1;
                    gap_next      = 8'd0;
                    state_next    = GAP;
                end else if (timeout_hit) begin
                    mos_req_next = 1'b0;
                    err_next     = 1'b1;
                    gap_next     = 8'd0;
                    state_next   = GAP;
                end else if ((state_reg == REQ) &&
                             (elapsed_reg == {8'd0, hold_reg} - 16'd1)) begin
                    mos_req_next = 1'b0;
                    state_next   = WAIT_ACK;
                end
            end
            GAP: begin
                if (gap_reg == 8'(GAP_CYC - 1)) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            elapsed_reg  <= 16'd0;
            hold_reg     <= 8'd1;
            gap_reg      <= 8'd0;
            mos_req_reg  <= 1'b0;
            mos_val_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            drop_reg     <= 1'b0;
            done_cnt_reg <= 16'd0;
        end else begin
            state_reg    <= state_next;
            elapsed_reg  <= elapsed_next;
            hold_reg     <= hold_next;
            gap_reg      <= gap_next;
            mos_req_reg  <= mos_req_next;
            mos_val_reg  <= mos_val_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            drop_reg     <= drop_next;
            done_cnt_reg <= done_cnt_next;
        end
    end

    assign mos_req  = mos_req_reg;
    assign mos_val  = mos_val_reg;
    assign cmd_busy = busy_reg;
    assign cmd_done = done_reg;
    assign cmd_err  = err_reg;
    assign cmd_drop = drop_reg;
    assign done_cnt = done_cnt_reg;

endmodule

// File: doc/mos_seq.md
# mos_seq

MOS switch request sequencer on the core-controller side of the MOS handshake. It accepts a one-shot command carrying the target MOS state and drives `mos_req`/`mos_val` toward the MOS controller. It then waits for `mos_ack` and reports the outcome: done, timeout, or dropped. The blanking and gap timing are sized to the controller's 3-cycle request edge-detect latency and to its combinational, level-type `mos_ack`.

## Interface
- ACK_BLANK, 3, cycles after `mos_req` rises during which `mos_ack` is ignored.
- GAP_CYC, 2, minimum cycles `mos_req` stays low after a transaction before the next one may start.
- clk  in  1  single clock
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
- cmd_start  in  1  single-cycle command pulse
- cmd_val  in  1  requested MOS state, sampled with `cmd_start`
- cmd_busy  out  1  high from the cycle after an accepted start until IDLE is re-entered
- cmd_done  out  1  1-cycle pulse: acknowledge received
- cmd_err  out  1  1-cycle pulse: acknowledge timeout
- cmd_drop  out  1  1-cycle pulse: `cmd_start` ignored because the block was busy
- done_cnt  out  16  count of completed (acknowledged) transactions; wraps at 0xFFFF->0
- mos_req  out  1  request to the MOS controller (controller acts on its rising edge)
- mos_val  out  1  MOS state presented with the request
- mos_ack  in  1  acknowledge from the MOS controller (level; may idle high)
- reg_req_hold  in  8  `mos_req` high time in cycles; 0 treated as 1
- reg_ack_timeout  in  16  timeout in cycles from the `mos_req` rise; 0 disables the timeout

## Operation
- FSM states:
  - IDLE -> REQ on `cmd_start`.
  - REQ -> WAIT_ACK when the hold expires.
  - REQ or WAIT_ACK -> GAP on ack acceptance or timeout.
  - GAP -> IDLE after GAP_CYC cycles.
- IDLE, `cmd_start`=1: latch `cmd_val` into `mos_val`, assert `mos_req`, clear `elapsed`, enter REQ.
- `elapsed` (16 bit):
  - Equals 0 in the first `mos_req`-high cycle.
  - Increments every cycle in REQ and WAIT_ACK.
  - Saturates at 0xFFFF.
- REQ:
  - `mos_req` stays high for H = max(`reg_req_hold`, 1) cycles.
  - If no ack is accepted in that time: drop `mos_req` and enter WAIT_ACK.
  - `reg_req_hold` is sampled at start.
- Ack acceptance, evaluated in REQ or WAIT_ACK: `mos_ack`=1 and `elapsed` >= ACK_BLANK. On acceptance:
  - `mos_req` goes to 0.
  - `cmd_done` pulses.
  - `done_cnt` increments.
  - Enter GAP.
- Timeout, evaluated in REQ or WAIT_ACK: `reg_ack_timeout`≠0, `elapsed`==`reg_ack_timeout`, and no ack accepted in that cycle. On timeout:
  - `mos_req` goes to 0.
  - `cmd_err` pulses.
  - Enter GAP.
- Ack and timeout in the same cycle: ack wins (done, no err).
- Timeout values below ACK_BLANK fire before any ack can be accepted; this is legal and the outcome is a timeout.
- GAP: `mos_req` is held 0 for GAP_CYC cycles, then IDLE. `cmd_busy` is still high in GAP.
- `cmd_start` while not in IDLE: ignored, `cmd_drop` pulses next cycle, `mos_val` unchanged.
- `mos_val` holds its last value between transactions. It changes only on an accepted start.

## Timing
- Reset values: `mos_req` 0, `mos_val` 0, `cmd_busy` 0, `cmd_done` 0, `cmd_err` 0, `cmd_drop` 0, `done_cnt` 0, FSM IDLE, `elapsed` 0.
- Reset mid-transaction: all outputs take their reset values the cycle after `rst` is sampled low. The controller then sees `mos_req` fall with no ack consumed.
- `cmd_start` sampled in cycle N: in N+1, `mos_req`=1, `mos_val`=`cmd_val`, `cmd_busy`=1, `elapsed`=0.
- Earliest ack acceptance is cycle N+1+ACK_BLANK (N+4). This matches the controller, which latches `mos_val` and can first raise `mos_ack` in N+4 when `reg_mos_time`<=2.
- Ack accepted in cycle A:
  - `mos_req`=0 and `cmd_done`=1 in A+1.
  - GAP occupies A+1..A+GAP_CYC.
  - `cmd_busy`=0 and IDLE in A+GAP_CYC+1 (A+3).
- Timeout detected in cycle T: `cmd_err`=1 in T+1; the same GAP sequence follows.
- Back-to-back throughput: at most one transaction per (5 + GAP_CYC) cycles.

## Test plan
- Responder model with `reg_mos_time`=2, `reg_req_hold`=1, start `cmd_val`=1 at N:
  - `mos_req` high only in N+1.
  - `mos_ack` accepted in N+4.
  - `cmd_done` in N+5, `done_cnt`=1.
  - `cmd_busy` low in N+7.
  - `mos_val`=1 throughout.
- `mos_ack` tied 1, `reg_req_hold`=8: ack accepted in N+4, not before. `mos_req` is therefore high only in N+1..N+4, and `cmd_done` pulses in N+5.
- `mos_ack` tied 0, `reg_ack_timeout`=20: timeout detected in N+21, `cmd_err` in N+22, no `cmd_done`, `done_cnt` unchanged. A subsequent start is accepted once `cmd_busy`=0.
- `reg_ack_timeout`=3 with `mos_ack`=1 in N+4: `cmd_done`=1, `cmd_err`=0.
- `cmd_start` pulsed in N, N+2 and N+6:
  - `cmd_drop` pulses in N+3 and N+7.
  - Exactly one transaction; `done_cnt` +1.
  - `mos_val` reflects the N command only.
- `rst`=0 while in WAIT_ACK: the next cycle has `mos_req`=0, `cmd_busy`=0 and `done_cnt`=0. After reset, a fresh start completes normally.
